// File: rtl/kore_rf_arb.sv
// Round-robin arbiter granting one function unit at a time access to the register-file port,
// with a bounded grant length and a mandatory one-cycle bus turnaround between owners.
module kore_rf_arb #(
  parameter int N        = 4,
  parameter int AW       = 5,
  parameter int DW       = 32,
  parameter int MAX_HOLD = 64,
  localparam int IDW     = (N > 1) ? $clog2(N) : 1,
  localparam int HW      = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req,
  input  logic [N-1:0]    fu_eop,
  input  logic [N*AW-1:0] fu_sel,
  input  logic [N-1:0]    fu_wt,
  input  logic [N*DW-1:0] fu_wdata,
  output logic [N-1:0]    gnt,
  output logic [IDW-1:0]  gnt_id,
  output logic            busy,
  output logic [AW-1:0]   rf_sel,
  output logic            rf_wt,
  output logic [DW-1:0]   rf_wdata,
  output logic            timeout_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t         state, state_d;
  logic [N-1:0]   gnt_d;
  logic [IDW-1:0] gnt_id_d;
  logic [IDW-1:0] rr_ptr, rr_ptr_d;
  logic [HW-1:0]  hold_cnt, hold_d;
  logic           tmo_d;
  logic [IDW-1:0] winner;
  logic           found;
  logic           owner_eop;
  logic           owner_req;
  logic           at_limit;

  // Round-robin scan starting at rr_ptr and wrapping past N-1.
  always_comb begin
    winner = rr_ptr;
    found  = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && req[(int'(rr_ptr) + i) % N]) begin
        found  = 1'b1;
        winner = IDW'((int'(rr_ptr) + i) % N);
      end
    end
  end

  assign owner_eop = fu_eop[gnt_id];
  assign owner_req = req[gnt_id];
  assign at_limit  = (hold_cnt == HW'(MAX_HOLD - 1));

  always_comb begin
    state_d  = state;
    gnt_d    = gnt;
    gnt_id_d = gnt_id;
    rr_ptr_d = rr_ptr;
    hold_d   = hold_cnt;
    tmo_d    = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          state_d         = GRANT;
          gnt_d           = '0;
          gnt_d[winner]   = 1'b1;
          gnt_id_d        = winner;
          hold_d          = '0;
          rr_ptr_d        = (winner == IDW'(N - 1)) ? '0 : winner + 1'b1;
        end
      end
      GRANT: begin
        if (owner_eop || !owner_req || at_limit) begin
          state_d = GAP;
          gnt_d   = '0;
          // A forced release is only reported when the owner gave no other reason to stop.
          tmo_d   = at_limit && !owner_eop && owner_req;
        end else begin
          hold_d  = hold_cnt + 1'b1;
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      gnt         <= '0;
      gnt_id      <= '0;
      rr_ptr      <= '0;
      hold_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_d;
      gnt         <= gnt_d;
      gnt_id      <= gnt_id_d;
      rr_ptr      <= rr_ptr_d;
      hold_cnt    <= hold_d;
      timeout_err <= tmo_d;
    end
  end

  assign busy = (state == GRANT);

  // Register-file port carries the owner's slice only while a grant is live.
  always_comb begin
    rf_sel   = '0;
    rf_wt    = 1'b0;
    rf_wdata = '0;
    if (busy) begin
      rf_sel   = fu_sel[int'(gnt_id) * AW +: AW];
      rf_wt    = fu_wt[gnt_id];
      rf_wdata = fu_wdata[int'(gnt_id) * DW +: DW];
    end
  end

endmodule

// File: doc/kore_rf_arb.md
KORE_RF_ARB -- requirements
Module: kore_rf_arb

Interface
REQ-001 SHALL have parameter N, default 4, number of function-unit requesters.
REQ-002 SHALL have parameter AW, default 5, register-file address width.
REQ-003 SHALL have parameter DW, default 32, register-file data width.
REQ-004 SHALL have parameter MAX_HOLD, default 64, maximum grant length in cycles (>=2).
REQ-005 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-007 SHALL have port req  input  N  per-requester access request, level.
REQ-008 SHALL have port fu_eop  input  N  per-requester end of operation, one-cycle pulse.
REQ-009 SHALL have port fu_sel  input  N*AW  per-requester register select; requester i at bits [i*AW +: AW].
REQ-010 SHALL have port fu_wt  input  N  per-requester write enable.
REQ-011 SHALL have port fu_wdata  input  N*DW  per-requester write data; requester i at bits [i*DW +: DW].
REQ-012 SHALL have port gnt  output  N  one-hot grant, registered.
REQ-013 SHALL have port gnt_id  output  clog2(N)  index of the current owner, registered.
REQ-014 SHALL have port busy  output  1  high while in GRANT.
REQ-015 SHALL have port rf_sel  output  AW  register select to the register file.
REQ-016 SHALL have port rf_wt  output  1  write enable to the register file.
REQ-017 SHALL have port rf_wdata  output  DW  write data to the register file.
REQ-018 SHALL have port timeout_err  output  1  one-cycle pulse on forced release.

Function
REQ-019 SHALL implement three states: IDLE, GRANT and GAP.
REQ-020 IDLE: if any req bit is high, SHALL pick a winner, go to GRANT next edge, set gnt/gnt_id to the winner, and clear hold_cnt to 0; otherwise stay in IDLE.
REQ-021 Winner selection SHALL be round-robin: first requester with req high, scanning from rr_ptr upward and wrapping from N-1 to 0.
REQ-022 On each grant, rr_ptr SHALL become (winner+1) mod N.
REQ-023 GRANT: hold_cnt SHALL increment by 1 per cycle, saturating at MAX_HOLD-1.
REQ-024 GRANT->GAP SHALL occur when fu_eop[owner]=1, or req[owner]=0, or hold_cnt==MAX_HOLD-1, whichever comes first; a grant therefore lasts at most MAX_HOLD cycles.
REQ-025 timeout_err SHALL pulse for the cycle after the exit edge only when the exit cause is hold_cnt alone; fu_eop[owner] or req drop in the same cycle SHALL suppress it.
REQ-026 GAP SHALL last exactly one cycle with gnt=0 and busy=0, then go to IDLE; the bus turnaround is not optional.
REQ-027 fu_eop and req from non-owners SHALL have no effect in GRANT.
REQ-028 rf_sel, rf_wt and rf_wdata SHALL be a combinational mux of the owner's fu_sel, fu_wt and fu_wdata slices while busy=1, and SHALL be 0 otherwise.
REQ-029 rf_wt SHALL never be high while busy=0.
REQ-030 gnt SHALL always be one-hot or zero; gnt_id SHALL hold its last value while gnt=0.
REQ-031 Latency: req first high in the cycle before edge k SHALL give gnt high after edge k when the arbiter is in IDLE; the minimum request-to-request gap between owners is 2 cycles (GAP plus IDLE).

Reset
REQ-032 When rst_n=0 at a rising edge, the block SHALL go to IDLE, set gnt=0, gnt_id=0, rr_ptr=0, hold_cnt=0, busy=0 and timeout_err=0; rf_* SHALL then read 0.
REQ-033 Reset asserted mid-GRANT SHALL drop the grant on that same edge with no timeout_err and no GAP cycle.
REQ-034 Reset SHALL have no effect between edges.

Verification
REQ-035 Bench SHALL cover: after reset, req=4'b0001 -> gnt=4'b0001 one cycle later; fu_wt[0]=1, fu_sel[0]=5'd3 -> rf_wt=1, rf_sel=3; fu_eop[0] pulse -> GAP, then gnt=0.
REQ-036 Bench SHALL cover: req=4'b1111 held, each owner pulsing eop after 3 cycles -> grant order 0,1,2,3,0 with exactly 2 idle cycles between grants.
REQ-037 Bench SHALL cover: MAX_HOLD=8, req[2] held, no eop -> gnt[2] high 8 cycles, then timeout_err pulses once, then gnt=0 and the grant re-issues after IDLE.
REQ-038 Bench SHALL cover: fu_eop[owner] in the cycle where hold_cnt==MAX_HOLD-1 -> normal release with timeout_err=0.
REQ-039 Bench SHALL cover: rst_n=0 for 1 cycle during GRANT of requester 1 -> gnt=0 and rf_wt=0 after that edge; the next arbitration starts from rr_ptr=0.
REQ-040 Bench SHALL cover: a non-owner toggling fu_wt and fu_eop during GRANT -> rf_wt follows the owner only, and the grant is unaffected.
